disp_scan_ctrl: RTL and testbench

//   Scan scheduler for the 4-digit 7-segment display. Time-multiplexes the shared

---
 rtl/disp_scan_ctrl.sv | 118 +++++++++++
 tb/tb_disp_scan_ctrl.sv | 164 ++++++++++++++++
 2 files changed

// File: rtl/disp_scan_ctrl.sv
// Scan scheduler for a 4-digit multiplexed 7-segment display: per-digit dead-time
// blanking, active-low anode select, and a frame-synchronous double-buffered value.
module disp_scan_ctrl #(
  parameter int unsigned DIGIT_TICKS = 100000,
  parameter int unsigned BLANK_TICKS = 1000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        en,
  input  logic [3:0]  digit_mask,
  input  logic        load,
  input  logic [15:0] value_in,
  output logic [3:0]  digit_sel,
  output logic [1:0]  digit_idx,
  output logic [15:0] value_q,
  output logic        frame_done
);

  localparam int unsigned MAXT = (DIGIT_TICKS > BLANK_TICKS) ? DIGIT_TICKS : BLANK_TICKS;
  localparam int unsigned CW   = $clog2(MAXT + 1);
  localparam logic [CW-1:0] DLAST = CW'(DIGIT_TICKS - 1);
  localparam logic [CW-1:0] BLAST = CW'((BLANK_TICKS == 0) ? 0 : BLANK_TICKS - 1);

  typedef enum logic [1:0] {IDLE, BLANK, ON} state_t;

  state_t        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [1:0]    idx_q, idx_d;
  logic [3:0]    sel_q, sel_d;
  logic          fd_q, fd_d;
  logic [15:0]   shadow_q, shadow_d;
  logic          pending_q, pending_d;
  logic [15:0]   value_d;
  logic          xfer;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    idx_d   = idx_q;
    xfer    = 1'b0;
    unique case (state_q)
      IDLE: begin
        xfer = 1'b1;
        if (en) begin
          idx_d   = 2'd0;
          cnt_d   = '0;
          state_d = (BLANK_TICKS == 0) ? ON : BLANK;
        end
      end
      BLANK: begin
        if (cnt_q == BLAST) begin
          state_d = ON;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      ON: begin
        if (cnt_q == DLAST) begin
          cnt_d   = '0;
          state_d = (BLANK_TICKS == 0) ? ON : BLANK;
          idx_d   = idx_q + 2'd1;
          xfer    = (idx_q == 2'd3);
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      default: state_d = IDLE;
    endcase

    // Disable overrides everything, including a frame-boundary transfer this cycle.
    if (!en) begin
      state_d = IDLE;
      idx_d   = 2'd0;
      cnt_d   = '0;
      xfer    = (state_q == IDLE);
    end

    // Outputs are derived from the next state so they line up with the state register.
    fd_d  = (state_d == ON) && (idx_d == 2'd3) && (cnt_d == DLAST);
    sel_d = ((state_d == ON) && digit_mask[idx_d]) ? ~(4'b0001 << idx_d) : 4'b1111;

    shadow_d  = load ? value_in : shadow_q;
    pending_d = load | pending_q;
    value_d   = value_q;
    if (xfer) begin
      value_d   = load ? value_in : shadow_q;
      pending_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      idx_q     <= 2'd0;
      sel_q     <= 4'b1111;
      fd_q      <= 1'b0;
      shadow_q  <= '0;
      pending_q <= 1'b0;
      value_q   <= '0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      idx_q     <= idx_d;
      sel_q     <= sel_d;
      fd_q      <= fd_d;
      shadow_q  <= shadow_d;
      pending_q <= pending_d;
      value_q   <= value_d;
    end
  end

  assign digit_sel  = sel_q;
  assign digit_idx  = idx_q;
  assign frame_done = fd_q;

endmodule

// File: tb/tb_disp_scan_ctrl.sv
// Directed bench for disp_scan_ctrl: table-driven frames plus hand-written
// sequences for disable/re-enable, async reset and the no-blanking configuration.
module tb_disp_scan_ctrl;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        en, load;
  logic [3:0]  mask;
  logic [15:0] vin;
  logic [3:0]  sel;
  logic [1:0]  idx;
  logic [15:0] val;
  logic        fd;

  logic        en_f;
  logic [3:0]  sel_f;
  logic [1:0]  idx_f;
  logic [15:0] val_f;
  logic        fd_f;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  disp_scan_ctrl #(.DIGIT_TICKS(4), .BLANK_TICKS(2)) u_dut (
    .clk(clk), .rst_n(rst_n), .en(en), .digit_mask(mask), .load(load),
    .value_in(vin), .digit_sel(sel), .digit_idx(idx), .value_q(val),
    .frame_done(fd)
  );

  disp_scan_ctrl #(.DIGIT_TICKS(1), .BLANK_TICKS(0)) u_fast (
    .clk(clk), .rst_n(rst_n), .en(en_f), .digit_mask(4'b1111), .load(1'b0),
    .value_in(16'h0000), .digit_sel(sel_f), .digit_idx(idx_f), .value_q(val_f),
    .frame_done(fd_f)
  );

  typedef struct {
    logic        en;
    logic [3:0]  mask;
    logic        load;
    logic [15:0] vin;
    logic [3:0]  sel;
    logic [1:0]  idx;
    logic        fd;
    logic [15:0] val;
  } vec_t;

  localparam int NFR = 7;
  vec_t tbl [NFR*24];

  task automatic step(input logic e, input logic [3:0] m, input logic l, input logic [15:0] v);
    en = e; mask = m; load = l; vin = v;
    @(posedge clk); #1;
    load = 1'b0;
  endtask

  task automatic chk(input string nm, input logic [3:0] s, input logic [1:0] i,
                     input logic f, input logic [15:0] v);
    checks++;
    if (sel !== s) begin errors++; $display("FAIL %s digit_sel got %b exp %b", nm, sel, s); end
    checks++;
    if (idx !== i) begin errors++; $display("FAIL %s digit_idx got %0d exp %0d", nm, idx, i); end
    checks++;
    if (fd !== f) begin errors++; $display("FAIL %s frame_done got %b exp %b", nm, fd, f); end
    checks++;
    if (val !== v) begin errors++; $display("FAIL %s value_q got %h exp %h", nm, val, v); end
  endtask

  initial begin
    logic [15:0] fval [NFR];
    logic [3:0]  m;
    fval = '{16'h0000, 16'h0000, 16'h0000, 16'h0000, 16'hBEEF, 16'h5678, 16'hA5A5};

    // Each frame: per slot 2 blank cycles then 4 ON cycles; frame_done on offset 23.
    for (int f = 0; f < NFR; f++) begin
      m = (f == 2) ? 4'b0101 : 4'b1111;
      for (int o = 0; o < 24; o++) begin
        int s, w;
        s = o / 6;
        w = o % 6;
        tbl[f*24+o].en   = 1'b1;
        tbl[f*24+o].mask = m;
        tbl[f*24+o].load = 1'b0;
        tbl[f*24+o].vin  = 16'h0000;
        tbl[f*24+o].sel  = (w < 2 || !m[s]) ? 4'b1111 : ~(4'b0001 << s);
        tbl[f*24+o].idx  = 2'(s);
        tbl[f*24+o].fd   = (o == 23);
        tbl[f*24+o].val  = fval[f];
      end
    end
    tbl[3*24+5].load  = 1'b1; tbl[3*24+5].vin  = 16'hBEEF;
    tbl[4*24+3].load  = 1'b1; tbl[4*24+3].vin  = 16'h1234;
    tbl[4*24+10].load = 1'b1; tbl[4*24+10].vin = 16'h5678;
    tbl[6*24+0].load  = 1'b1; tbl[6*24+0].vin  = 16'hA5A5;

    en = 1'b0; en_f = 1'b0; mask = 4'b1111; load = 1'b0; vin = '0;
    rst_n = 1'b0;
    #23 rst_n = 1'b1;
    @(posedge clk); #1;
    chk("reset", 4'b1111, 2'd0, 1'b0, 16'h0000);
    step(1'b0, 4'b1111, 1'b0, 16'h0000);
    chk("idle", 4'b1111, 2'd0, 1'b0, 16'h0000);

    for (int k = 0; k < NFR*24; k++) begin
      string nm;
      step(tbl[k].en, tbl[k].mask, tbl[k].load, tbl[k].vin);
      nm = $sformatf("tbl_f%0d_o%0d", k / 24, k % 24);
      chk(nm, tbl[k].sel, tbl[k].idx, tbl[k].fd, tbl[k].val);
    end

    // Frame 7: pending load, then drop en during digit 2 ON.
    for (int o = 0; o <= 14; o++) begin
      step(1'b1, 4'b1111, (o == 2), 16'hCAFE);
    end
    chk("d2_on", 4'b1011, 2'd2, 1'b0, 16'hA5A5);
    step(1'b0, 4'b1111, 1'b0, 16'h0000);
    chk("en_drop", 4'b1111, 2'd0, 1'b0, 16'hA5A5);
    step(1'b0, 4'b1111, 1'b0, 16'h0000);
    chk("idle_xfer", 4'b1111, 2'd0, 1'b0, 16'hCAFE);
    step(1'b1, 4'b1111, 1'b0, 16'h0000);
    chk("reen_blank0", 4'b1111, 2'd0, 1'b0, 16'hCAFE);
    step(1'b1, 4'b1111, 1'b0, 16'h0000);
    chk("reen_blank1", 4'b1111, 2'd0, 1'b0, 16'hCAFE);
    step(1'b1, 4'b1111, 1'b0, 16'h0000);
    chk("reen_on", 4'b1110, 2'd0, 1'b0, 16'hCAFE);
    step(1'b1, 4'b1111, 1'b0, 16'h0000);
    step(1'b1, 4'b1111, 1'b0, 16'h0000);
    step(1'b1, 4'b1111, 1'b1, 16'hBBBB);
    step(1'b1, 4'b1111, 1'b0, 16'h0000);
    chk("slot1_blank", 4'b1111, 2'd1, 1'b0, 16'hCAFE);

    // Async reset mid-BLANK, well away from any clock edge.
    rst_n = 1'b0;
    #2;
    chk("async_rst", 4'b1111, 2'd0, 1'b0, 16'h0000);
    #2 rst_n = 1'b1;
    step(1'b0, 4'b1111, 1'b0, 16'h0000);
    step(1'b0, 4'b1111, 1'b0, 16'h0000);
    chk("rst_clears_pending", 4'b1111, 2'd0, 1'b0, 16'h0000);

    // No blanking, one tick per digit.
    en_f = 1'b1;
    for (int k = 0; k < 8; k++) begin
      logic [3:0] es;
      logic [1:0] ei;
      @(posedge clk); #1;
      ei = 2'(k % 4);
      es = ~(4'b0001 << ei);
      checks++;
      if (sel_f !== es) begin errors++; $display("FAIL fast_sel%0d got %b exp %b", k, sel_f, es); end
      checks++;
      if (idx_f !== ei) begin errors++; $display("FAIL fast_idx%0d got %0d exp %0d", k, idx_f, ei); end
      checks++;
      if (fd_f !== (ei == 2'd3)) begin
        errors++; $display("FAIL fast_fd%0d got %b exp %b", k, fd_f, (ei == 2'd3));
      end
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
